halfadder_scheduler: RTL and testbench

Round-robin scheduler that shares one registered `halfadder` datapath among `NUM_REQ` requesters. It arbitrates requests, latches the winner's operands, drives the half adder and waits for its result. It then returns `sum`/`carry` tagged with the requester ID, or an error if the adder does not answer within `TIMEOUT` cycles. It sits between the requester-side logic and the shared `halfadder` instance in the top-level datapath.

---
 rtl/halfadder_scheduler.sv | 159 +++++++++++++++
 tb/tb_halfadder_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/halfadder_scheduler.sv
// Round-robin front end sharing one registered half adder among NUM_REQ requesters.
// state | meaning: IDLE | arbitrating, no operation outstanding; WAIT | operands issued, awaiting ha_valid or timeout
module halfadder_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] a_in,
  input  logic [NUM_REQ-1:0] b_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_sum,
  output logic               rsp_carry,
  output logic               rsp_err,
  output logic               busy,
  output logic               ha_a,
  output logic               ha_b,
  output logic               ha_start,
  input  logic               ha_sum,
  input  logic               ha_carry,
  input  logic               ha_valid
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_WAIT = 1'b1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic               state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               start_q, start_d;
  logic               ha_a_q, ha_a_d;
  logic               ha_b_q, ha_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               rsp_sum_q, rsp_sum_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [IDW-1:0]     win_idx;
  logic [IDW:0]       scan;

  // Scan last+1, last+2, ... with wrap; the extra bit keeps the sum from overflowing.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan = {1'b0, last_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!win_found && req[scan[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_d       = '0;
    start_d     = 1'b0;
    ha_a_d      = ha_a_q;
    ha_b_d      = ha_b_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_WAIT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          start_d = 1'b1;
          ha_a_d  = a_in[win_idx];
          ha_b_d  = b_in[win_idx];
          last_d  = win_idx;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // During the issue cycle the adder still shows the previous result.
        if (cnt_q != '0) begin
          if (ha_valid) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = last_q;
            rsp_sum_d   = ha_sum;
            rsp_carry_d = ha_carry;
            rsp_err_d   = 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_id_d    = last_q;
            rsp_sum_d   = 1'b0;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
          end
        end
      end
    endcase
    busy_d = (state_d == ST_WAIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= IDW'(NUM_REQ - 1);
      gnt_q       <= '0;
      start_q     <= 1'b0;
      ha_a_q      <= 1'b0;
      ha_b_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      start_q     <= start_d;
      ha_a_q      <= ha_a_d;
      ha_b_q      <= ha_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign ha_start  = start_q;
  assign ha_a      = ha_a_q;
  assign ha_b      = ha_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_halfadder_scheduler.sv
// Bench for halfadder_scheduler: directed vector table, corner sequences and a random run against a timestamp model.
module tb_halfadder_scheduler;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 15;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_REQ-1:0] req, a_in, b_in, gnt;
  logic               rsp_valid, rsp_sum, rsp_carry, rsp_err, busy;
  logic [IDW-1:0]     rsp_id;
  logic               ha_a, ha_b, ha_start, ha_sum, ha_carry, ha_valid;
  logic [1:0]         ha_mode;

  int n_pass = 0;
  int n_tot  = 0;

  halfadder_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy), .ha_a(ha_a), .ha_b(ha_b), .ha_start(ha_start),
    .ha_sum(ha_sum), .ha_carry(ha_carry), .ha_valid(ha_valid)
  );

  always #5 clk = ~clk;

  // Shared adder: mode 0 answers one cycle after ha_start, 1 never answers, 2 holds valid high.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ha_sum <= 1'b0; ha_carry <= 1'b0; ha_valid <= 1'b0;
    end else begin
      ha_sum   <= ha_a ^ ha_b;
      ha_carry <= ha_a & ha_b;
      case (ha_mode)
        2'd0:    ha_valid <= ha_start;
        2'd1:    ha_valid <= 1'b0;
        default: ha_valid <= 1'b1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One request through an idle scheduler; called at a negedge, returns at the response negedge.
  task automatic do_op(input int id, input logic a, input logic b, input logic es, input logic ec);
    req = '0; req[id] = 1'b1; a_in[id] = a; b_in[id] = b;
    @(negedge clk);
    chk("op_gnt", gnt, 32'(4'(1) << id));
    chk("op_start", ha_start, 1);
    chk("op_operands", {ha_a, ha_b}, {a, b});
    chk("op_no_rsp_at_gnt", rsp_valid, 0);
    req = '0;
    @(negedge clk);
    chk("op_mid", {gnt, ha_start, busy, rsp_valid}, {4'b0000, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_fields", {rsp_id, rsp_sum, rsp_carry, rsp_err}, {2'(id), es, ec, 1'b0});
  endtask

  typedef struct { int id; logic a; logic b; logic s; logic c; } vec_t;
  vec_t vecs[7];
  int   fair_exp[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int g_idx[8], g_cyc[8], ng, k, w;
    int e, free_at, rsp_at, m_last, p_id;
    logic p_s, p_c;
    logic [3:0] exp_gnt;
    logic exp_start, exp_busy, exp_rv, exp_a, exp_b;
    logic [4:0] exp_rsp;

    vecs[0] = '{2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{3, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset with all requests pending
    reset = 1'b0; req = 4'b1111; a_in = '0; b_in = '0; ha_mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, busy, ha_a, ha_b, ha_start}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("first_gnt_req0", gnt, 4'b0001);
    chk("first_busy", busy, 1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    chk("first_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err}, {1'b1, 2'd0, 3'b000});

    for (int i = 0; i < 7; i++) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);
    @(negedge clk);
    chk("rsp_hold", {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err}, {1'b0, 2'd1, 1'b1, 1'b0, 1'b0});

    // Fairness with req=1011 held
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; req = 4'b1011;
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt != 0 && ng < 8) begin
        w = -1;
        for (int j = 0; j < NUM_REQ; j++) if (gnt[j]) w = j;
        g_idx[ng] = w; g_cyc[ng] = c; ng++;
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
    chk("fair_count", 32'(ng >= 6), 1);
    for (int j = 0; j < 6; j++) begin
      chk("fair_order", g_idx[j], fair_exp[j]);
      if (j > 0) chk("fair_spacing", g_cyc[j] - g_cyc[j-1], 3);
    end

    // Timeout from requester 1, then normal service
    ha_mode = 2'd1;
    req = 4'b0010; a_in[1] = 1'b1; b_in[1] = 1'b1;
    k = 0;
    while (gnt == 0 && k < 10) begin @(negedge clk); k++; end
    chk("to_gnt", gnt, 4'b0010);
    req = '0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k <= 40);
    chk("to_latency", k, TIMEOUT);
    chk("to_fields", {rsp_id, rsp_sum, rsp_carry, rsp_err}, {2'd1, 3'b001});
    ha_mode = 2'd0;
    do_op(0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Valid held high: response must reflect the new operands
    ha_mode = 2'd2;
    do_op(3, 1'b1, 1'b1, 1'b0, 1'b1);
    do_op(3, 1'b1, 1'b0, 1'b1, 1'b0);
    ha_mode = 2'd0;

    // Reset one cycle after the grant
    req = 4'b0100; a_in[2] = 1'b1; b_in[2] = 1'b1;
    @(negedge clk);
    chk("rw_gnt", gnt, 4'b0100);
    req = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("rw_async_clear", {gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, busy, ha_a, ha_b, ha_start}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rw_no_rsp", rsp_valid, 0);
    end
    reset = 1'b1; req = 4'b1111;
    @(negedge clk);
    chk("rw_restart_req0", gnt, 4'b0001);
    req = '0;
    for (int c = 0; c < 3; c++) @(negedge clk);

    // Random traffic against a timestamp model
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    e = 0; free_at = 0; rsp_at = -1; m_last = NUM_REQ - 1; p_id = 0; p_s = 0; p_c = 0;
    exp_rsp = '0; exp_a = 0; exp_b = 0;
    for (int it = 0; it < 500; it++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!req[r] && $urandom_range(0, 2) == 0) begin
          req[r] = 1'b1; a_in[r] = 1'($urandom_range(0, 1)); b_in[r] = 1'($urandom_range(0, 1));
        end
      exp_gnt = '0; exp_start = 0; exp_rv = 0; w = -1;
      if (e == rsp_at) begin
        exp_rv = 1; exp_rsp = {2'(p_id), p_s, p_c, 1'b0};
      end
      if (e >= free_at && req != 0) begin
        for (int j = 1; j <= NUM_REQ; j++)
          if (w < 0 && req[(m_last + j) % NUM_REQ]) w = (m_last + j) % NUM_REQ;
        exp_gnt = 4'(1) << w; exp_start = 1;
        exp_a = a_in[w]; exp_b = b_in[w];
        p_id = w; p_s = a_in[w] ^ b_in[w]; p_c = a_in[w] & b_in[w];
        rsp_at = e + 2; free_at = e + 3; m_last = w;
      end
      exp_busy = (e + 1 < free_at);
      @(negedge clk);
      chk("rnd_gnt", gnt, exp_gnt);
      chk("rnd_start_busy", {ha_start, busy}, {exp_start, exp_busy});
      chk("rnd_operands", {ha_a, ha_b}, {exp_a, exp_b});
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      chk("rnd_rsp_fields", {rsp_id, rsp_sum, rsp_carry, rsp_err}, exp_rsp);
      if (w >= 0) req[w] = 1'b0;
      e++;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
